// File: rtl/ysyx_23060136_shift_pkg.sv
// Shared types and default sizing for the iterative EXU shift unit.
package ysyx_23060136_shift_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam int DEF_STEP    = 4;

  typedef enum logic [1:0] {
    SLL        = 2'b00,
    SRL        = 2'b01,
    ROR_OR_SRL = 2'b10,
    SRA        = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/ysyx_23060136_exu_shift_step.sv
// Combinational single step: shifts din by k (0..STEP) positions for the given op.
// Rotate support for op 10 only when YSYX_23060136_SHIFT_ROT_EN is defined.
module ysyx_23060136_exu_shift_step
  import ysyx_23060136_shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STEP   = DEF_STEP,
  parameter int KW     = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] din,
  input  logic [KW-1:0]     k,
  input  shift_op_e         op,
  output logic [DATA_W-1:0] dout
);

  // NOTE: dout gets a value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dout = din >> k;
    case (op)
      SLL: dout = din << k;
      SRL: dout = din >> k;
      SRA: dout = $signed(din) >>> k;
`ifdef YSYX_23060136_SHIFT_ROT_EN
      // Shifting a doubled copy right makes the low half the rotated word.
      ROR_OR_SRL: dout = DATA_W'({din, din} >> k);
`else
      ROR_OR_SRL: dout = din >> k;
`endif
      default: dout = din >> k;
    endcase
  end

endmodule

// File: rtl/ysyx_23060136_exu_shift_iter.sv
// Iterative shift unit: at most STEP positions per cycle, valid/ready in and out.
// Define YSYX_23060136_SHIFT_ROT_EN to make op 10 a rotate-right instead of SRL.
module ysyx_23060136_exu_shift_iter
  import ysyx_23060136_shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int STEP    = DEF_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_din,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_dout,
  output logic               busy
);

  localparam int KW = $clog2(STEP + 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, step_out;
  logic [SHAMT_W-1:0] rem_q, rem_next;
  shift_op_e          op_q;
  logic [31:0]        rem_w;
  logic [KW-1:0]      k;
  logic               accept;

  assign in_ready  = (state_q == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_dout  = (state_q == DONE) ? acc_q : '0;

  // k = min(rem, STEP); k never exceeds rem, so rem_next cannot underflow.
  always_comb begin
    rem_w    = 32'(rem_q);
    k        = (rem_w < 32'(STEP)) ? KW'(rem_w) : KW'(STEP);
    rem_next = SHAMT_W'(rem_w - 32'(k));
  end

  ysyx_23060136_exu_shift_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .KW     (KW)
  ) u_step (
    .din  (acc_q),
    .k    (k),
    .op   (op_q),
    .dout (step_out)
  );

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // flush overrides every transition, including the DONE handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = (in_shamt == '0) ? DONE : SHIFT;
        SHIFT:   if (rem_next == '0) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are reset too, so nothing from an aborted request survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
      op_q  <= SLL;
    end else if (accept) begin
      acc_q <= in_din;
      rem_q <= in_shamt;
      op_q  <= shift_op_e'(in_op);
    end else if (state_q == SHIFT && !flush) begin
      acc_q <= step_out;
      rem_q <= rem_next;
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_exu_shift_iter.sv
// Scoreboard bench for the iterative shift unit against an arithmetic reference model.
module tb_ysyx_23060136_exu_shift_iter;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_din = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_dout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  ysyx_23060136_exu_shift_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_din    (in_din),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dout  (out_dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] o);
    logic [31:0] r;
    case (o)
      2'b00: r = d << s;
      2'b11: r = $signed(d) >>> s;
`ifdef YSYX_23060136_SHIFT_ROT_EN
      2'b10: begin
        r = d;
        for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
      end
`else
      2'b10: r = d >> s;
`endif
      default: r = d >> s;
    endcase
    return r;
  endfunction

  // Monitor: a result leaves the DUT on every sampled valid&&ready without flush.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out_dout, 32'hxxxx_xxxx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("dout", out_dout, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request while idle and returns 1 time unit after the accept edge.
  task automatic accept_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_din   = d;
    in_shamt = s;
    in_op    = o;
    tick();
    in_valid = 1'b0;
    in_din   = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                        input int stall);
    int n;
    int lat;
    logic [31:0] held;
    lat = 1 + (int'(s) + STEP - 1) / STEP;
    out_ready = (stall == 0);
    exp_q.push_back(ref_shift(d, int'(s), o));
    accept_req(d, s, o);
    n = 1;
    while (!out_valid && n < 40) begin
      check("busy_while_shifting", {31'd0, busy}, 32'd1);
      tick();
      n++;
    end
    check("latency", n, lat);
    if (stall > 0) begin
      held = out_dout;
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'($urandom);
        in_din   = $urandom;
        check("hold_dout", out_dout, held);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        tick();
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
    end else begin
      check("busy_in_done", {31'd0, busy}, 32'd1);
      tick();
    end
    check("idle_after_handshake", {30'd0, busy, out_valid}, 32'd0);
    check("dout_zero_idle", out_dout, 32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_dout", out_dout, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(32'h8000_0000, 5'd31, 2'b11, 0);
    run_op(32'h0000_0001, 5'd0,  2'b00, 0);
    run_op(32'hF000_000F, 5'd4,  2'b01, 0);
    run_op(32'hF000_000F, 5'd5,  2'b01, 0);
    run_op(32'h0000_0001, 5'd1,  2'b10, 0);
    run_op(32'h8765_4321, 5'd13, 2'b11, 5);

    // Flush in the third cycle of a long SRA: result must never appear.
    out_ready = 1'b1;
    accept_req(32'h8000_1234, 5'd20, 2'b11);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_to_idle", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("flush_no_valid", seen, 0);

    // Flush coincident with in_valid: request is refused.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_shamt = 5'd0;
    #3;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_no_accept", {31'd0, busy}, 32'd0);
    tick();

    // Asynchronous reset mid-operation.
    accept_req(32'h1234_5678, 5'd24, 2'b00);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {29'd0, busy, out_valid, in_ready}, 32'd1);
    check("midrst_dout", out_dout, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, 5'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_exu_shift_iter.md
Name: ysyx_23060136_exu_shift_iter

Overview:
Iterative, multi-cycle shift unit for the EXU. It is the sequential counterpart of the single-cycle combinational barrel shifter: it trades area for latency by shifting at most STEP bit positions per cycle. Requests arrive from the ALU issue side over a valid/ready handshake. Results return to writeback over a second valid/ready handshake. It serves area-reduced core configurations and also acts as the golden multi-cycle model for cross-checking the barrel shifter.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; DATA_W == 2**SHAMT_W.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1 <= STEP <= DATA_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; aborts any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  request ready.
- in_din  in  DATA_W  operand to shift.
- in_shamt  in  SHAMT_W  shift amount.
- in_op  in  2  00 SLL, 01 SRL, 11 SRA, 10 see Optional Feature.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_dout  out  DATA_W  result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all datapath registers cleared.
  - out_valid=0, out_dout=0, busy=0, in_ready=1.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !flush. A request is accepted on a clock edge where in_valid && in_ready.
- Accept:
  - Latch din into acc, shamt into rem, and op.
  - If shamt==0, go to DONE; otherwise go to SHIFT.
- SHIFT (one step per cycle):
  - Step amount k = min(rem, STEP).
  - acc <= acc shifted by k: SLL fills zeros; SRL fills zeros; SRA fills with acc[DATA_W-1].
  - rem <= rem - k.
  - When rem - k == 0, go to DONE.
  - rem never underflows.
- Latency from accept edge to out_valid high is 1 + ceil(shamt/STEP) cycles. With defaults, that is 1 cycle minimum and 9 cycles maximum.
- DONE:
  - out_valid=1 and out_dout=acc.
  - Both are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
- No new request is accepted in the cycle the result handshakes. The next accept is possible at the earliest one cycle later. Throughput is not a goal.
- out_dout is driven from acc only in DONE; it reads 0 in IDLE and SHIFT.
- flush: at the next edge, from any state, go to IDLE.
  - out_valid falls; the in-flight result is discarded.
  - flush has priority over the DONE handshake and over a simultaneous in_valid (the request is not accepted).
- Shift semantics must equal the combinational shifter bit-exactly for every din/shamt/op.
- Reset asserted mid-operation clears everything immediately. No output is produced for the aborted request.
- in_din/in_shamt/in_op are sampled only at accept; changes afterwards are ignored.

Optional Feature:
- Macro: YSYX_23060136_SHIFT_ROT_EN.
- Defined:
  - op 10 = ROR (rotate right).
  - Each step rotates acc right by k, bits leaving the LSB re-entering at the MSB.
  - Latency rule is unchanged.
- Undefined: op 10 executes exactly as SRL, and no rotate logic is synthesized.

Decomposition:
- Package ysyx_23060136_shift_pkg:
  - typedef enum shift_op_e {SLL=2'b00, SRL=2'b01, ROR_OR_SRL=2'b10, SRA=2'b11}.
  - typedef enum state_e {IDLE, SHIFT, DONE}.
  - Default constants for DATA_W/SHAMT_W/STEP.
- Sub-module ysyx_23060136_exu_shift_step: purely combinational, shifts by 0..STEP for the given op. Instantiated once in the iterative unit.

Test Plan (defaults):
- SRA din=0x8000_0000 shamt=31 -> out_dout=0xFFFF_FFFF, out_valid high 9 cycles after the accept edge.
- SLL din=0x0000_0001 shamt=0 -> out_dout=0x0000_0001 one cycle after accept; busy high for exactly that cycle with out_ready=1.
- SRL din=0xF000_000F shamt=4 -> out_dout=0x0F00_0000, latency 2; shamt=5 -> 0x0780_0000, latency 3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_dout stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge.
- flush in cycle 3 of SRA shamt=20 -> IDLE next edge, out_valid never rises; flush coincident with in_valid -> request not accepted.
- Macro on: ROR din=0x0000_0001 shamt=1 -> 0x8000_0000. Macro off: same op -> 0x0000_0000.
